// File: rtl/playback_rate_ctrl_pkg.sv
// Shared types and constants for the playback-rate scheduler.
// Key-event priority lives here so every user encodes it the same way.
package playback_pkg;

    localparam int RATE_W = 32;
    localparam logic [RATE_W-1:0] SYS_CLK_HZ = 32'd50_000_000;

    typedef logic [RATE_W-1:0] rate_t;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_UP,
        KEY_DOWN,
        KEY_RESET
    } key_evt_e;

    // Reset wins; up and down together cancel each other out.
    function automatic key_evt_e decode_keys(input logic rise_up,
                                             input logic rise_down,
                                             input logic rise_reset);
        key_evt_e evt;
        evt = KEY_NONE;
        if (rise_reset) begin
            evt = KEY_RESET;
        end else if (rise_up && !rise_down) begin
            evt = KEY_UP;
        end else if (rise_down && !rise_up) begin
            evt = KEY_DOWN;
        end
        return evt;
    endfunction

endpackage

// File: rtl/playback_rate_ctrl_key_rise_detect.sv
// Rising-edge detector for one key level. The history register resets high
// so a key held through reset is not seen as a fresh press on release.
module key_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= key_i;
        end
    end

    assign rise_o = key_i & ~prev_q;

endmodule

// File: rtl/playback_rate_ctrl.sv
// Playback-rate scheduler: key-stepped, clamped sample rate plus an
// exact-average sample_tick from a phase accumulator.
// Optional: define PLAYBACK_PAUSE_EN to add a pause input that freezes the accumulator.
module playback_rate_ctrl
    import playback_pkg::*;
#(
    parameter logic [31:0] IN_CLOCK_FREQ = SYS_CLK_HZ,
    parameter logic [31:0] DEFAULT_RATE  = 32'd22_000,
    parameter logic [31:0] RATE_STEP     = 32'd2_000,
    parameter logic [31:0] MIN_RATE      = 32'd2_000,
    parameter logic [31:0] MAX_RATE      = 32'd64_000
) (
    input  logic        in_clk,
    input  logic        rst_n,
    input  logic        speed_up,
    input  logic        speed_down,
    input  logic        speed_reset,
`ifdef PLAYBACK_PAUSE_EN
    input  logic        pause,
`endif
    output logic [31:0] rate_hz,
    output logic        sample_tick,
    output logic        at_min,
    output logic        at_max
);

    logic [2:0] keys;
    logic [2:0] rises;
    key_evt_e   key_evt;

    rate_t       rate_q, rate_d;
    rate_t       acc_q, acc_d;
    logic        tick_q, tick_d;
    logic [RATE_W:0] up_sum;
    rate_t       phase_sum;

    assign keys = {speed_reset, speed_down, speed_up};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            key_rise_detect u_rise (
                .clk    (in_clk),
                .rst_n  (rst_n),
                .key_i  (keys[gi]),
                .rise_o (rises[gi])
            );
        end
    endgenerate

    assign key_evt = decode_keys(rises[0], rises[1], rises[2]);

    // One spare bit so the up-step clamp is immune to wrap-around.
    assign up_sum = {1'b0, rate_q} + {1'b0, RATE_STEP};

    always_comb begin
        rate_d = rate_q;
        unique case (key_evt)
            KEY_RESET: rate_d = DEFAULT_RATE;
            KEY_UP:    rate_d = (up_sum > {1'b0, MAX_RATE}) ? MAX_RATE : up_sum[RATE_W-1:0];
            KEY_DOWN:  rate_d = (rate_q < MIN_RATE + RATE_STEP) ? MIN_RATE : rate_q - RATE_STEP;
            default:   rate_d = rate_q;
        endcase
    end

    // acc stays below IN_CLOCK_FREQ, so acc + rate never exceeds 32 bits.
    assign phase_sum = acc_q + rate_q;

    always_comb begin
        acc_d  = phase_sum;
        tick_d = 1'b0;
        if (phase_sum >= IN_CLOCK_FREQ) begin
            acc_d  = phase_sum - IN_CLOCK_FREQ;
            tick_d = 1'b1;
        end
`ifdef PLAYBACK_PAUSE_EN
        if (pause) begin
            acc_d  = acc_q;
            tick_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= DEFAULT_RATE;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            rate_q <= rate_d;
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign rate_hz     = rate_q;
    assign sample_tick = tick_q;
    assign at_min      = (rate_q == MIN_RATE);
    assign at_max      = (rate_q == MAX_RATE);

endmodule

// File: tb/tb_playback_rate_ctrl.sv
// Randomized and directed bench for playback_rate_ctrl against a cumulative-phase
// reference model (tick whenever floor(total_phase / F) advances).
module tb_playback_rate_ctrl;

    localparam longint F    = 50_000_000;
    localparam int     DEF  = 22_000;
    localparam int     STEP = 2_000;
    localparam int     MINR = 2_000;
    localparam int     MAXR = 64_000;

    logic        in_clk      = 1'b0;
    logic        rst_n       = 1'b1;
    logic        speed_up    = 1'b0;
    logic        speed_down  = 1'b0;
    logic        speed_reset = 1'b0;
`ifdef PLAYBACK_PAUSE_EN
    logic        pause       = 1'b0;
`endif
    logic [31:0] rate_hz;
    logic        sample_tick;
    logic        at_min;
    logic        at_max;

    always #5 in_clk = ~in_clk;

    playback_rate_ctrl dut (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .speed_up    (speed_up),
        .speed_down  (speed_down),
        .speed_reset (speed_reset),
`ifdef PLAYBACK_PAUSE_EN
        .pause       (pause),
`endif
        .rate_hz     (rate_hz),
        .sample_tick (sample_tick),
        .at_min      (at_min),
        .at_max      (at_max)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint m_phase   = 0;
    int     m_rate    = DEF;
    logic   m_tick    = 1'b0;
    logic [2:0] m_prev = 3'b111;
    int     cyc       = 0;
    logic   last_tick = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic ru, rd, rr, paused;
        if (!rst_n) begin
            m_rate  = DEF;
            m_phase = 0;
            m_tick  = 1'b0;
            m_prev  = 3'b111;
            cyc     = 0;
        end else begin
            cyc++;
            paused = 1'b0;
`ifdef PLAYBACK_PAUSE_EN
            paused = pause;
`endif
            if (paused) begin
                m_tick = 1'b0;
            end else begin
                m_tick  = ((m_phase + m_rate) / F) != (m_phase / F);
                m_phase = m_phase + m_rate;
            end
            ru = speed_up    & ~m_prev[0];
            rd = speed_down  & ~m_prev[1];
            rr = speed_reset & ~m_prev[2];
            if (rr)
                m_rate = DEF;
            else if (ru && !rd)
                m_rate = (m_rate + STEP > MAXR) ? MAXR : m_rate + STEP;
            else if (rd && !ru)
                m_rate = (m_rate - STEP < MINR) ? MINR : m_rate - STEP;
            m_prev = {speed_reset, speed_down, speed_up};
        end
    endtask

    task automatic tick_cycle();
        @(posedge in_clk);
        model_step();
        #1;
        check_eq("rate_hz", rate_hz, m_rate);
        check_eq("sample_tick", {31'd0, sample_tick}, {31'd0, m_tick});
        check_eq("at_min", {31'd0, at_min}, {31'd0, (m_rate == MINR)});
        check_eq("at_max", {31'd0, at_max}, {31'd0, (m_rate == MAXR)});
        check_eq("no_back_to_back", {31'd0, last_tick & sample_tick}, 32'd0);
        last_tick = sample_tick;
    endtask

    task automatic press(input int which);
        if (which == 0) speed_up = 1'b1;
        else if (which == 1) speed_down = 1'b1;
        else speed_reset = 1'b1;
        tick_cycle();
        speed_up = 1'b0;
        speed_down = 1'b0;
        speed_reset = 1'b0;
        tick_cycle();
    endtask

    task automatic wait_first_tick(input int expect_cyc);
        int n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!sample_tick && n < 5000);
        check_eq("first_tick_cycle", cyc, expect_cyc);
    endtask

    task automatic release_reset();
        @(negedge in_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_rate_async", rate_hz, DEF);
        check_eq("reset_tick_async", {31'd0, sample_tick}, 32'd0);
        repeat (3) tick_cycle();
        release_reset();

        // First tick lands at ceil(F / 22000) after release
        wait_first_tick(2273);

        // Step up to the upper clamp and try to exceed it
        for (int i = 0; i < 21; i++) press(0);
        check_eq("up21_rate", rate_hz, MAXR);
        check_eq("up21_at_max", {31'd0, at_max}, 32'd1);
        press(0);
        check_eq("up22_rate", rate_hz, MAXR);

        // Back to default, then down to the lower clamp
        press(2);
        check_eq("reset_key_rate", rate_hz, DEF);
        for (int i = 0; i < 10; i++) press(1);
        check_eq("down10_rate", rate_hz, MINR);
        check_eq("down10_at_min", {31'd0, at_min}, 32'd1);
        press(1);
        check_eq("down11_rate", rate_hz, MINR);

        // Simultaneous up and down cancel
        press(2);
        speed_up = 1'b1;
        speed_down = 1'b1;
        tick_cycle();
        speed_up = 1'b0;
        speed_down = 1'b0;
        tick_cycle();
        check_eq("up_down_same_cycle", rate_hz, DEF);

        // Reset key beats up key at 30000
        for (int i = 0; i < 4; i++) press(0);
        check_eq("rate_30000", rate_hz, 30_000);
        speed_up = 1'b1;
        speed_reset = 1'b1;
        tick_cycle();
        check_eq("reset_beats_up", rate_hz, DEF);
        speed_up = 1'b0;
        speed_reset = 1'b0;
        tick_cycle();

        // Hold speed_up across an asynchronous reset taken mid-period
        speed_up = 1'b1;
        tick_cycle();
        repeat (700) tick_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_rate", rate_hz, DEF);
        check_eq("async_reset_tick", {31'd0, sample_tick}, 32'd0);
        repeat (2) tick_cycle();
        release_reset();
        wait_first_tick(2273);
        check_eq("held_key_no_step", rate_hz, DEF);
        speed_up = 1'b0;
        tick_cycle();

`ifdef PLAYBACK_PAUSE_EN
        // A 1000-cycle pause shifts the first tick by exactly 1000 cycles
        @(negedge in_clk) rst_n = 1'b0;
        repeat (2) tick_cycle();
        release_reset();
        repeat (100) tick_cycle();
        pause = 1'b1;
        repeat (1000) tick_cycle();
        pause = 1'b0;
        wait_first_tick(2273 + 1000);
`endif

        // Randomized key activity checked every cycle by the model
        for (int i = 0; i < 20000; i++) begin
            speed_up    = ($urandom_range(0, 15) == 0);
            speed_down  = ($urandom_range(0, 15) == 0);
            speed_reset = ($urandom_range(0, 63) == 0);
`ifdef PLAYBACK_PAUSE_EN
            pause       = ($urandom_range(0, 31) == 0);
`endif
            tick_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
